// File: rtl/order_book_scheduler.sv
// order_book_scheduler
// Front-end sequencer for one side of the order book. Buffers ADD / CANCEL /
// EXECUTE requests from NUM_REQ sources in per-source FIFOs, picks one
// round-robin, and issues it on the start_book interface. The next issue is
// held off until the book is idle and its price tree has re-settled.
//
// Optional feature: define SCHED_CANCEL_PRIORITY_EN to let CANCEL/EXECUTE
// heads win over ADD heads. The default build (macro undefined) arbitrates
// pure round-robin regardless of request code.

package order_book_pkg;
    localparam logic [2:0] ADD_ORDER     = 3'b001;
    localparam logic [2:0] CANCEL_ORDER  = 3'b010;
    localparam logic [2:0] EXECUTE_ORDER = 3'b011;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == ADD_ORDER) || (code == CANCEL_ORDER) || (code == EXECUTE_ORDER);
    endfunction

    function automatic logic is_urgent(input logic [2:0] code);
        return (code == CANCEL_ORDER) || (code == EXECUTE_ORDER);
    endfunction
endpackage

module order_book_scheduler
    import order_book_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int ID_W         = 9,
    parameter int PRICE_W      = 7,
    parameter int QTY_W        = 16,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                                           clk_in,
    input  logic                                           rst_n_in,
    input  logic [NUM_REQ-1:0]                             req_valid_i,
    output logic [NUM_REQ-1:0]                             req_ready_o,
    input  logic [3*NUM_REQ-1:0]                           req_type_i,
    input  logic [ID_W*NUM_REQ-1:0]                        req_order_id_i,
    input  logic [PRICE_W*NUM_REQ-1:0]                     req_price_i,
    input  logic [QTY_W*NUM_REQ-1:0]                       req_qty_i,
    output logic                                           book_start_o,
    output logic [2:0]                                     book_request_o,
    output logic [ID_W-1:0]                                book_order_id_o,
    output logic [PRICE_W-1:0]                             book_price_o,
    output logic [QTY_W-1:0]                               book_qty_o,
    input  logic                                           book_busy_i,
    input  logic                                           book_price_valid_i,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] issue_src_o,
    output logic                                           drop_o,
    output logic                                           timeout_o,
    output logic [31:0]                                    issued_cnt_o
);

    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]         code;
        logic [ID_W-1:0]    id;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Source index that is 'offs' places after 'base', wrapping at NUM_REQ.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return SRC_W'(sum);
    endfunction

    // Per-source FIFO storage and bookkeeping
    entry_t             r_mem    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr [NUM_REQ];
    logic [PTR_W-1:0]   r_rd_ptr [NUM_REQ];
    logic [CNT_W-1:0]   r_count  [NUM_REQ];
    logic               r_ready_en;

    entry_t             w_in     [NUM_REQ];
    entry_t             w_head   [NUM_REQ];
    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_nonempty;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;

    // Arbitration results
    logic               w_grant_vld;
    logic [SRC_W-1:0]   w_grant;
    entry_t             w_sel;

    // Sequencer state and registered outputs
    state_t             r_state;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               r_start;
    logic               r_drop;
    logic               r_timeout;
    logic [31:0]        r_issued_cnt;
    logic [SRC_W-1:0]   r_issue_src;
    entry_t             r_book;

    // Slice the flat request buses into entries and derive FIFO status
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_in[i].code  = req_type_i[3*i +: 3];
            w_in[i].id    = req_order_id_i[ID_W*i +: ID_W];
            w_in[i].price = req_price_i[PRICE_W*i +: PRICE_W];
            w_in[i].qty   = req_qty_i[QTY_W*i +: QTY_W];
            w_head[i]     = r_mem[i][r_rd_ptr[i]];
            w_full[i]     = (r_count[i] == FULL_CNT);
            w_nonempty[i] = (r_count[i] != '0);
        end
    end

    // Ready comes only from the registered count, so a full FIFO refuses a
    // push even in a cycle where it is also being popped.
    assign req_ready_o = {NUM_REQ{r_ready_en}} & ~w_full;
    assign w_push      = req_valid_i & req_ready_o;

    // Round-robin winner among non-empty FIFOs, starting at r_rr_ptr
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path through the block leaves it unassigned
        // (which would infer a latch).
        w_grant_vld = 1'b0;
        w_grant     = '0;
`ifdef SCHED_CANCEL_PRIORITY_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_vld && w_nonempty[rr_idx(r_rr_ptr, k)] &&
                is_urgent(w_head[rr_idx(r_rr_ptr, k)].code)) begin
                w_grant_vld = 1'b1;
                w_grant     = rr_idx(r_rr_ptr, k);
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_vld && w_nonempty[rr_idx(r_rr_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant     = rr_idx(r_rr_ptr, k);
            end
        end
    end

    // Pop the winning head whenever the sequencer is idle
    always_comb begin
        w_pop = '0;
        if (r_state == S_IDLE && w_grant_vld) w_pop[w_grant] = 1'b1;
        w_sel = w_head[w_grant];
    end

    // FIFO storage writes
    // NOTE: the entry array has no reset; a slot is only ever read after it
    // was written, because the pointers and counts below are reset.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_in[i];
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ready_en <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values regardless of block order.
            r_ready_en <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
            end
        end
    end

    // IDLE -> ISSUE -> WAIT sequencer with registered book-side outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_wait_cnt   <= '0;
            r_start      <= 1'b0;
            r_drop       <= 1'b0;
            r_timeout    <= 1'b0;
            r_issued_cnt <= '0;
            r_issue_src  <= '0;
            r_book       <= '0;
        end else begin
            r_start <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_rr_ptr <= rr_idx(w_grant, 1);
                        if (is_legal(w_sel.code)) begin
                            r_book       <= w_sel;
                            r_issue_src  <= w_grant;
                            r_start      <= 1'b1;
                            r_issued_cnt <= r_issued_cnt + 32'd1;
                            r_state      <= S_ISSUE;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // The first WAIT cycle is ignored: the book has not yet
                    // reacted to the start pulse and may still look settled.
                    if (r_wait_cnt != '0 && !book_busy_i && book_price_valid_i) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == WAIT_MAX) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign book_start_o    = r_start;
    assign book_request_o  = r_book.code;
    assign book_order_id_o = r_book.id;
    assign book_price_o    = r_book.price;
    assign book_qty_o      = r_book.qty;
    assign issue_src_o     = r_issue_src;
    assign drop_o          = r_drop;
    assign timeout_o       = r_timeout;
    assign issued_cnt_o    = r_issued_cnt;

endmodule

// File: tb/tb_order_book_scheduler.sv
// Self-checking bench for order_book_scheduler: directed stimulus pushes the
// expected book-side events into a scoreboard queue; a monitor pops and
// compares whenever the DUT pulses book_start_o or drop_o.
module tb_order_book_scheduler;
    import order_book_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 9;
    localparam int PRICE_W = 7;
    localparam int QTY_W   = 16;
    localparam int SETTLE  = 8;

    logic                         clk_in = 1'b0;
    logic                         rst_n_in;
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [3*NUM_REQ-1:0]         req_type_i;
    logic [ID_W*NUM_REQ-1:0]      req_order_id_i;
    logic [PRICE_W*NUM_REQ-1:0]   req_price_i;
    logic [QTY_W*NUM_REQ-1:0]     req_qty_i;
    logic                         book_start_o;
    logic [2:0]                   book_request_o;
    logic [ID_W-1:0]              book_order_id_o;
    logic [PRICE_W-1:0]           book_price_o;
    logic [QTY_W-1:0]             book_qty_o;
    logic                         book_busy_i;
    logic                         book_price_valid_i;
    logic [0:0]                   issue_src_o;
    logic                         drop_o;
    logic                         timeout_o;
    logic [31:0]                  issued_cnt_o;

    order_book_scheduler #(
        .NUM_REQ(NUM_REQ), .FIFO_DEPTH(4), .ID_W(ID_W), .PRICE_W(PRICE_W),
        .QTY_W(QTY_W), .WAIT_TIMEOUT(255)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_order_id_i(req_order_id_i),
        .req_price_i(req_price_i), .req_qty_i(req_qty_i),
        .book_start_o(book_start_o), .book_request_o(book_request_o),
        .book_order_id_o(book_order_id_o), .book_price_o(book_price_o),
        .book_qty_o(book_qty_o), .book_busy_i(book_busy_i),
        .book_price_valid_i(book_price_valid_i), .issue_src_o(issue_src_o),
        .drop_o(drop_o), .timeout_o(timeout_o), .issued_cnt_o(issued_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit         is_drop;
        int         src;
        logic [2:0] code;
        int         id;
        int         price;
        int         qty;
    } exp_t;

    exp_t sb[$];
    int   start_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic busy_hold = 1'b0;
    int   settle = 0;

    assign book_busy_i = busy_hold;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Book model: price tree drops price_valid for SETTLE cycles after a start.
    initial begin
        book_price_valid_i = 1'b1;
        forever begin
            @(negedge clk_in);
            if (book_start_o) settle = SETTLE;
            else if (settle > 0) settle--;
            book_price_valid_i = (settle == 0);
        end
    end

    // Monitor: compare every start/drop pulse against the scoreboard head.
    initial begin
        int         exp_cnt;
        logic [34:0] last;
        exp_t       e;
        exp_cnt = 0;
        last    = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                exp_cnt = 0;
                last    = '0;
            end else begin
                if (book_start_o || drop_o) begin
                    check("start/drop exclusive", book_start_o & drop_o, 1'b0);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected event: start=%0b drop=%0b id=%0d, expected none",
                                 book_start_o, drop_o, book_order_id_o);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_drop) begin
                            check("drop pulse", {book_start_o, drop_o}, 2'b01);
                        end else begin
                            check("start pulse", {book_start_o, drop_o}, 2'b10);
                            exp_cnt++;
                            check("issue_src", issue_src_o, e.src);
                            check("book_request", book_request_o, e.code);
                            check("book_order_id", book_order_id_o, e.id);
                            check("book_price", book_price_o, e.price);
                            check("book_qty", book_qty_o, e.qty);
                            check("issued_cnt", issued_cnt_o, exp_cnt);
                            start_cyc.push_back(cyc);
                            last = {book_request_o, book_order_id_o, book_price_o, book_qty_o};
                        end
                    end
                end
                if (!book_start_o)
                    check("book fields held",
                          {book_request_o, book_order_id_o, book_price_o, book_qty_o}, last);
            end
        end
    end

    task automatic set_src(input int s, input logic v, input logic [2:0] code,
                           input int id, input int price, input int qty);
        req_valid_i[s]                     = v;
        req_type_i[3*s +: 3]               = code;
        req_order_id_i[ID_W*s +: ID_W]     = ID_W'(id);
        req_price_i[PRICE_W*s +: PRICE_W]  = PRICE_W'(price);
        req_qty_i[QTY_W*s +: QTY_W]        = QTY_W'(qty);
    endtask

    task automatic clr_src(input int s);
        @(negedge clk_in);
        req_valid_i[s] = 1'b0;
    endtask

    // Drive one request and hold it until the source FIFO accepts it.
    task automatic push(input int s, input logic [2:0] code, input int id,
                        input int price, input int qty);
        bit acc;
        acc = 1'b0;
        for (int c = 0; c < 400 && !acc; c++) begin
            @(negedge clk_in);
            set_src(s, 1'b1, code, id, price, qty);
            acc = req_ready_o[s];
            @(posedge clk_in);
        end
        check("push accepted", acc, 1'b1);
    endtask

    task automatic expect_issue(input int s, input logic [2:0] code, input int id,
                                input int price, input int qty);
        exp_t e;
        e.is_drop = 1'b0; e.src = s; e.code = code; e.id = id; e.price = price; e.qty = qty;
        sb.push_back(e);
    endtask

    task automatic expect_drop();
        exp_t e;
        e.is_drop = 1'b1; e.src = 0; e.code = '0; e.id = 0; e.price = 0; e.qty = 0;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk_in);
            c++;
        end
        check("scoreboard drained", sb.size(), 0);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in    = 1'b0;
        busy_hold   = 1'b0;
        req_valid_i = '0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        start_cyc.delete();
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        req_valid_i    = '0;
        req_type_i     = '0;
        req_order_id_i = '0;
        req_price_i    = '0;
        req_qty_i      = '0;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("reset start", book_start_o, 1'b0);
        check("reset ready", req_ready_o, 2'b00);
        check("reset issued_cnt", issued_cnt_o, 32'd0);
        check("reset timeout", timeout_o, 1'b0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("ready after reset", req_ready_o, 2'b11);

        // Single ADD, then a second one to measure issue spacing
        expect_issue(0, ADD_ORDER, 5, 40, 100);
        push(0, ADD_ORDER, 5, 40, 100);
        expect_issue(0, ADD_ORDER, 6, 41, 50);
        push(0, ADD_ORDER, 6, 41, 50);
        clr_src(0);
        drain(100);
        check("t1 issued_cnt", issued_cnt_o, 32'd2);
        if (start_cyc.size() >= 2)
            check("t1 spacing >= 10", (start_cyc[1] - start_cyc[0]) >= 10, 1'b1);

        // Both sources push three ADDs in the same cycles -> strict alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_issue(0, ADD_ORDER, 10 + i, 20 + i, 200 + i);
            expect_issue(1, ADD_ORDER, 30 + i, 60 + i, 300 + i);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            set_src(0, 1'b1, ADD_ORDER, 10 + i, 20 + i, 200 + i);
            set_src(1, 1'b1, ADD_ORDER, 30 + i, 60 + i, 300 + i);
            check("t2 both ready", req_ready_o, 2'b11);
            @(posedge clk_in);
        end
        @(negedge clk_in);
        req_valid_i = '0;
        drain(200);

        // FSM parked in WAIT by a busy book; src1 fills its FIFO
        do_reset();
        busy_hold = 1'b1;
        expect_issue(0, ADD_ORDER, 1, 10, 10);
        push(0, ADD_ORDER, 1, 10, 10);
        clr_src(0);
        repeat (4) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            expect_issue(1, (i % 2 == 0) ? ADD_ORDER : EXECUTE_ORDER, 100 + i, i, 7 + i);
            push(1, (i % 2 == 0) ? ADD_ORDER : EXECUTE_ORDER, 100 + i, i, 7 + i);
        end
        @(negedge clk_in);
        check("t3 ready low after 4th", req_ready_o[1], 1'b0);
        expect_issue(1, CANCEL_ORDER, 104, 0, 0);
        set_src(1, 1'b1, CANCEL_ORDER, 104, 0, 0);
        repeat (6) @(negedge clk_in);
        check("t3 5th held off", req_ready_o[1], 1'b0);
        busy_hold = 1'b0;
        push(1, CANCEL_ORDER, 104, 0, 0);
        clr_src(1);
        drain(300);

        // Illegal head is dropped, following legal entry issues
        do_reset();
        expect_drop();
        expect_issue(0, EXECUTE_ORDER, 77, 0, 12);
        push(0, 3'b111, 9, 9, 9);
        push(0, EXECUTE_ORDER, 77, 0, 12);
        clr_src(0);
        drain(100);
        check("t4 issued_cnt", issued_cnt_o, 32'd1);

        // Book stuck busy -> timeout, then resume, then async reset mid-WAIT
        do_reset();
        busy_hold = 1'b1;
        expect_issue(0, ADD_ORDER, 200, 100, 1000);
        push(0, ADD_ORDER, 200, 100, 1000);
        clr_src(0);
        repeat (200) @(negedge clk_in);
        check("t5 timeout not yet", timeout_o, 1'b0);
        repeat (100) @(negedge clk_in);
        check("t5 timeout set", timeout_o, 1'b1);
        expect_issue(0, CANCEL_ORDER, 201, 0, 0);
        push(0, CANCEL_ORDER, 201, 0, 0);
        clr_src(0);
        drain(20);
        push(1, ADD_ORDER, 300, 1, 1);
        push(1, ADD_ORDER, 301, 2, 2);
        clr_src(1);
        repeat (3) @(negedge clk_in);
        check("t5 pre-reset issued_cnt", issued_cnt_o, 32'd2);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("t5 async start", book_start_o, 1'b0);
        check("t5 async fields",
              {book_request_o, book_order_id_o, book_price_o, book_qty_o}, 35'd0);
        check("t5 async flags", {issue_src_o, drop_o, timeout_o}, 3'b000);
        check("t5 async issued_cnt", issued_cnt_o, 32'd0);
        check("t5 async ready", req_ready_o, 2'b00);
        repeat (2) @(negedge clk_in);
        rst_n_in  = 1'b1;
        busy_hold = 1'b0;
        repeat (40) @(negedge clk_in);
        check("t5 fifos emptied", issued_cnt_o, 32'd0);
        check("t5 ready after reset", req_ready_o, 2'b11);

        // src0 ADD vs src1 CANCEL pending together with rr_ptr = 0
        do_reset();
`ifdef SCHED_CANCEL_PRIORITY_EN
        expect_issue(1, CANCEL_ORDER, 51, 0, 0);
        expect_issue(0, ADD_ORDER, 50, 60, 70);
`else
        expect_issue(0, ADD_ORDER, 50, 60, 70);
        expect_issue(1, CANCEL_ORDER, 51, 0, 0);
`endif
        @(negedge clk_in);
        set_src(0, 1'b1, ADD_ORDER, 50, 60, 70);
        set_src(1, 1'b1, CANCEL_ORDER, 51, 0, 0);
        @(negedge clk_in);
        req_valid_i = '0;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
